mul_sequencer: RTL

Iterative shift-add multiplier controller for the single-cycle RISC-V core. It handles the MUL operation (ALU operation code 4'b1010) over several cycles instead of in one combinational multiply. While it runs, it stalls the core's PC and register-file write, then returns the low DATA_WIDTH bits of the product. It sits beside the ALU: the ALU control output selects it, and its result is muxed into the write-back path when `done` is high.

---
 rtl/mul_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the MUL ALU op. It stalls the core while it iterates and
// pulses done_o for one cycle with the low DATA_WIDTH bits of the product.
module mul_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  MUL_CODE   = 4'b1010,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]       count_q, count_d;

  logic                  accept;
  logic [DATA_WIDTH-1:0] acc_step;
  logic [DATA_WIDTH-1:0] mplier_step;
  logic                  last_iter;

  assign accept      = start_i && (alu_operation_i == MUL_CODE) && !flush_i;
  assign acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_step = mplier_q >> 1;
  assign last_iter   = (count_q == LastCnt) || (EARLY_EXIT && (mplier_step == '0));

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    busy_o   = 1'b0;
    stall_o  = 1'b0;
    done_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Reset holds state in IDLE, so gating here keeps stall low throughout reset.
        stall_o = accept && rst_ni;
        if (accept) begin
          mcand_d  = operand_a_i;
          mplier_d = operand_b_i;
          acc_d    = '0;
          count_d  = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        busy_o  = 1'b1;
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_step;
          count_d  = count_q + 1'b1;
          if (last_iter) begin
            result_d = acc_step;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        busy_o  = 1'b1;
        done_o  = !flush_i;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule
